md_sched: RTL and testbench

//  Multi-cycle multiply/divide unit and its pipeline scheduler for the 5-stage MIPS core.

---
 rtl/md_sched.sv | 153 +++++++++++++++
 tb/tb_md_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide unit with HI/LO ownership and D-stage stall generation.
// Results are computed at launch and held until the programmed latency elapses.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
  localparam logic [2:0] OpMfhi  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  logic [63:0]       prod_s, prod_u;
  logic              a_neg, b_neg, div_zero;
  logic [31:0]       a_mag, b_mag, den_s, den_u;
  logic [31:0]       q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Datapath: both products and both quotients from the current E-stage operands.
  always_comb begin
    prod_s   = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
    prod_u   = {32'd0, rs_E} * {32'd0, rt_E};
    a_neg    = rs_E[31];
    b_neg    = rt_E[31];
    a_mag    = a_neg ? (32'd0 - rs_E) : rs_E;
    b_mag    = b_neg ? (32'd0 - rt_E) : rt_E;
    div_zero = (rt_E == 32'd0);
    // Divisor forced to 1 on zero so the divider never sees /0; result is discarded anyway.
    den_s    = div_zero ? 32'd1 : b_mag;
    den_u    = div_zero ? 32'd1 : rt_E;
    q_mag    = a_mag / den_s;
    r_mag    = a_mag % den_s;
    q_s      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_s      = a_neg ? (32'd0 - r_mag) : r_mag;
    q_u      = rs_E / den_u;
    r_u      = rs_E % den_u;
  end

  // Next-state: launch/MTHI/MTLO in idle, countdown and HI/LO commit while busy.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (md_op)
            OpMult: begin
              state_d  = StBusy;
              cnt_d    = CntW'(MULT_CYCLES);
              res_hi_d = prod_s[63:32];
              res_lo_d = prod_s[31:0];
            end
            OpMultu: begin
              state_d  = StBusy;
              cnt_d    = CntW'(MULT_CYCLES);
              res_hi_d = prod_u[63:32];
              res_lo_d = prod_u[31:0];
            end
            OpDiv, OpDivu: begin
              state_d = StBusy;
              cnt_d   = CntW'(DIV_CYCLES);
              // Divide by zero recommits the current HI/LO, which cannot change while busy.
              if (div_zero) begin
                res_hi_d = hi_q;
                res_lo_d = lo_q;
              end else if (md_op == OpDiv) begin
                res_hi_d = r_s;
                res_lo_d = q_s;
              end else begin
                res_hi_d = r_u;
                res_lo_d = q_u;
              end
            end
            OpMthi:  hi_d = rs_E;
            OpMtlo:  lo_d = rs_E;
            default: ;
          endcase
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // Outputs: stall covers the launch cycle as well as the busy window.
  always_comb begin
    busy     = (state_q == StBusy);
    stall_md = md_use_D & (busy | (start & (md_op <= OpDivu)));
    hi       = hi_q;
    lo       = lo_q;
    md_out   = (md_op == OpMfhi) ? hi_q : lo_q;
  end

  // The D-stage stall must keep any state-changing MD op out of E while busy.
  assert property (@(posedge clk) disable iff (reset) !(start && busy && (md_op <= OpMtlo)))
    else $error("md_sched: state-changing op issued while busy");

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected latency/HI/LO, a monitor
// checks them when busy falls; stall, md_out and MTHI/MTLO are checked inline.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_E, rt_E;
  logic        md_use_D;
  logic        busy, stall_md;
  logic [31:0] hi, lo, md_out;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo),
    .md_out   (md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: count busy cycles; on the falling edge of busy compare against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_cnt++;
    if (prev_busy && busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_completion: got busy fall, expected none");
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_lat"}, 32'(busy_cnt), 32'(e.lat));
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
      end
      busy_cnt = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    rs_E  = a;
    rt_E  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] eh,
                     input logic [31:0] el);
    exp_t e;
    int   n;
    e.lat = lat; e.hi = eh; e.lo = el; e.name = name;
    exp_q.push_back(e);
    issue(op, a, b);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles, expected busy=0", name, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_E = '0; rt_E = '0; md_use_D = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", {31'd0, stall_md}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // MULT with an MFLO waiting in D: stall spans launch cycle plus five busy cycles.
    e.lat = 5; e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFA; e.name = "mult";
    exp_q.push_back(e);
    md_use_D = 1'b1;
    start = 1'b1; md_op = 3'd0; rs_E = 32'hFFFF_FFFE; rt_E = 32'd3;
    @(negedge clk);
    check("stall_launch", {31'd0, stall_md}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_busy%0d", i), {31'd0, stall_md}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_release", {31'd0, stall_md}, 32'd0);
    check("mflo_out", md_out, 32'hFFFF_FFFA);
    @(posedge clk); #1;
    md_use_D = 1'b0;

    run("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu",  3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run("div_negdiv", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // MTHI/MTLO take effect on their edge with no busy period.
    issue(3'd4, 32'h11, 32'd0);
    @(negedge clk);
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    issue(3'd5, 32'h22, 32'd0);
    md_op = 3'd6;
    @(negedge clk);
    check("mtlo_lo", lo, 32'h22);
    check("mfhi_out", md_out, 32'h11);
    @(posedge clk); #1;

    run("div_zero", 3'd2, 32'd100, 32'd0, 10, 32'h11, 32'h22);

    // Reset during the third busy cycle of a DIV discards the result.
    e.lat = 3; e.hi = 32'h0; e.lo = 32'h0; e.name = "div_reset";
    exp_q.push_back(e);
    issue(3'd2, 32'd50, 32'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    md_use_D = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_md}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
